serial_addsub_ctrl: RTL and testbench

//   Bit-serial add/subtract sequencer built around one full-adder/full-subtractor bit cell.
//   It accepts a WIDTH-bit operation on a start pulse and drives the cell LSB-first, one bit per clock.
//   It accumulates the result and the final carry/borrow, then signals completion with done.
//   It sits between a simple command source and the shared 1-bit arithmetic cell, trading latency for area.

---
 rtl/serial_addsub_ctrl.sv | 83 ++++++++
 tb/tb_serial_addsub_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer driving one full-adder/subtractor cell LSB-first
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d, c_q, c_d, cout_q, cout_d;
    logic             ai, bi, s, cn, last;
    always_comb begin
        ai      = a_q[idx_q];
        bi      = b_q[idx_q];
        s       = ai ^ bi ^ c_q;
        cn      = op_q ? ((~ai & bi) | (~(ai ^ bi) & c_q)) : ((ai & bi) | (bi & c_q) | (ai & c_q));
        last    = idx_q == IW'(WIDTH - 1);
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        res_d   = res_q;
        cout_d  = cout_q;
        if (start && state_q != RUN) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = opa;
            b_d     = opb;
            op_d    = op;
            c_d     = cin;
            res_d   = '0;
            cout_d  = 1'b0;
        end else if (state_q == RUN) begin
            res_d[idx_q] = s;
            c_d          = cn;
            // idx holds on the last bit so it never leaves 0..WIDTH-1
            idx_d        = last ? idx_q : idx_q + IW'(1);
            cout_d       = last ? cn : cout_q;
            state_d      = last ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end
    assign busy   = state_q == RUN;
    assign done   = state_q == DONE;
    assign result = res_q;
    assign cout   = cout_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_addsub_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, op, cin, busy, done, cout;
    logic [7:0] opa, opb, result;
    logic       start1, op1, opa1, opb1, cin1, busy1, done1, result1, cout1;
    typedef struct {logic [8:0] v; int cyc;} exp_t;
    exp_t q8[$];
    exp_t q1[$];
    int n_tests = 0, n_fail = 0, cyc = 0, nb;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    serial_addsub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout)
    );
    serial_addsub_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .opa(opa1), .opb(opb1), .cin(cin1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                check("result8", {23'd0, cout, result}, {23'd0, e.v});
                check("latency8", cyc, e.cyc);
                check("busy_done_excl8", {31'd0, busy}, 0);
            end
        end
        if (rst === 1'b0 && done1 === 1'b1) begin
            if (q1.size() == 0) check("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                check("result1", {30'd0, cout1, result1}, {23'd0, e.v});
                check("latency1", cyc, e.cyc);
            end
        end
    end
    task automatic issue8(input logic o, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] ev);
        exp_t e;
        op = o; opa = a; opb = b; cin = c; start = 1'b1;
        e.v = ev; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic wait8(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) return;
            if (busy) n++;
            @(posedge clk); #1;
        end
        check("timeout8", 0, 1);
    endtask
    initial begin
        logic [7:0] a, b;
        logic       o, c;
        logic [8:0] m;
        rst = 1'b0; start = 0; op = 0; opa = 0; opb = 0; cin = 0;
        start1 = 0; op1 = 0; opa1 = 0; opb1 = 0; cin1 = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_result", {23'd0, cout, result}, 0);
        check("rst_flags", {30'd0, busy, done}, 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        issue8(0, 8'h35, 8'h4A, 0, 9'h07F);
        wait8(nb);
        check("busy_cycles", nb, 8);
        @(posedge clk); #1;
        issue8(0, 8'hFF, 8'h01, 0, 9'h100);
        wait8(nb);
        issue8(0, 8'hFF, 8'hFF, 1, 9'h1FF);
        wait8(nb);
        issue8(1, 8'h10, 8'h20, 0, 9'h1F0);
        wait8(nb);
        issue8(1, 8'h05, 8'h03, 1, 9'h001);
        wait8(nb);
        repeat (2) @(posedge clk);
        #1;
        issue8(0, 8'h12, 8'h34, 0, 9'h046);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; opa = 8'hAA; opb = 8'h55; op = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait8(nb);
        issue8(1, 8'h80, 8'h01, 0, 9'h07F);
        wait8(nb);
        check("busy_cycles_b2b", nb, 8);
        @(posedge clk); #1;
        issue8(0, 8'h0F, 8'h01, 0, 9'h010);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_result", {23'd0, cout, result}, 0);
        check("abort_flags", {30'd0, busy, done}, 0);
        void'(q8.pop_back());
        #3 rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("no_done_after_abort", {31'd0, done}, 0);
        end
        issue8(0, 8'h0F, 8'h01, 0, 9'h010);
        wait8(nb);
        begin
            exp_t e;
            op1 = 1; opa1 = 0; opb1 = 1; cin1 = 0; start1 = 1'b1;
            e.v = 9'h003; e.cyc = cyc + 1 + 1;
            q1.push_back(e);
            @(posedge clk); #1;
            start1 = 1'b0;
            check("busy1", {31'd0, busy1}, 1);
            @(posedge clk); #1;
            check("done1", {31'd0, done1}, 1);
        end
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            o = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            m = o ? ({1'b0, a} - {1'b0, b} - {8'd0, c}) : ({1'b0, a} + {1'b0, b} + {8'd0, c});
            issue8(o, a, b, c, m);
            wait8(nb);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", q8.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
